// File: rtl/pcileech_tlp_pkg.sv
// Shared types for the TLP stream packer: packed qword entry layout, fill FSM states
// and the helper that turns one AXI-stream beat into a stored entry.
package pcileech_tlp_pkg;

  localparam int TLP_QW_W = 66;

  typedef struct packed {
    logic        keep2;
    logic        last;
    logic [31:0] dw2;
    logic [31:0] dw1;
  } tlp_qw_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DISCARD
  } pack_state_t;

  function automatic tlp_qw_t qw_pack(input logic [63:0] data, input logic keep2, input logic last);
    tlp_qw_t qw;
    qw.keep2 = keep2;
    qw.last  = last;
    qw.dw2   = data[63:32];
    qw.dw1   = data[31:0];
    return qw;
  endfunction

endpackage

// File: rtl/pcileech_tlp_slot_ram.sv
// DEPTH slots of NUM_QW packed qwords each; one entry written per beat, a whole slot
// cleared at TLP start, and a full slot read out into a register on pop.
module pcileech_tlp_slot_ram
  import pcileech_tlp_pkg::*;
#(
  parameter int NUM_QW = 18,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1,
  parameter int WIDX_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_en,
  input  logic                         wr_en,
  input  logic [PTR_W-1:0]             wr_slot,
  input  logic [WIDX_W-1:0]            wr_idx,
  input  tlp_qw_t                      wr_qw,
  input  logic                         rd_en,
  input  logic [PTR_W-1:0]             rd_slot,
  output logic [TLP_QW_W*NUM_QW-1:0]   rd_data
);

  tlp_qw_t                     mem_q [DEPTH][NUM_QW];
  tlp_qw_t                     mem_d [DEPTH][NUM_QW];
  logic [TLP_QW_W*NUM_QW-1:0]  rd_data_q;
  logic [TLP_QW_W*NUM_QW-1:0]  rd_data_d;

  // Clear and write share an edge on beat 0; the write of entry 0 wins over the clear.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      for (int i = 0; i < NUM_QW; i++) begin
        mem_d[wr_slot][i] = '0;
      end
    end
    if (wr_en) begin
      mem_d[wr_slot][wr_idx] = wr_qw;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int i = 0; i < NUM_QW; i++) begin
        rd_data_d[i*TLP_QW_W +: TLP_QW_W] = mem_q[rd_slot][i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        for (int i = 0; i < NUM_QW; i++) begin
          mem_q[s][i] <= '0;
        end
      end
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pcileech_tlp_stream_packer.sv
// Packs 64-bit AXI-stream TLPs into wide NUM_QW-entry words, queues them in a DEPTH-slot
// FIFO and hands them out over has_data/req_data/valid; oversize TLPs are dropped and counted.
module pcileech_tlp_stream_packer
  import pcileech_tlp_pkg::*;
#(
  parameter int NUM_QW = 18,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [63:0]                 s_data,
  input  logic [7:0]                  s_keep,
  input  logic                        s_last,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [TLP_QW_W*NUM_QW-1:0]  tlp_data,
  output logic                        tlp_valid,
  output logic                        tlp_has_data,
  input  logic                        tlp_req_data,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_SW = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(NUM_QW + 1);
  localparam int WIDX_W = $clog2(NUM_QW);

  pack_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_SW-1:0] count_q, count_d;
  logic              has_data_q, has_data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              ready_en_q;

  logic accept, pop, commit, drop, wr_en, clr_en;
  logic unused_keep;

  assign unused_keep = ^{s_keep[7:5], s_keep[3:0]};

  assign s_ready = ready_en_q & ((state_q == DISCARD) | (count_q != CNT_SW'(DEPTH)));
  assign accept  = s_valid & s_ready;
  assign pop     = tlp_req_data & has_data_q;

  // Fill FSM: beat index NUM_QW means the TLP no longer fits and the rest is swallowed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    drop    = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          clr_en = 1'b1;
          wr_en  = 1'b1;
          if (s_last) begin
            commit = 1'b1;
          end else begin
            state_d = FILL;
            idx_d   = IDX_W'(1);
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (idx_q == IDX_W'(NUM_QW)) begin
            idx_d = '0;
            if (s_last) begin
              drop    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DISCARD;
            end
          end else begin
            wr_en = 1'b1;
            if (s_last) begin
              commit  = 1'b1;
              state_d = IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) begin
          drop    = 1'b1;
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (commit) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({commit, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    has_data_d = (count_d != '0);
    valid_d    = pop;
    drop_d     = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      has_data_q <= 1'b0;
      valid_q    <= 1'b0;
      drop_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      has_data_q <= has_data_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
      ready_en_q <= 1'b1;
    end
  end

  pcileech_tlp_slot_ram #(
    .NUM_QW (NUM_QW),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .WIDX_W (WIDX_W)
  ) u_slot_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_en  (clr_en),
    .wr_en   (wr_en),
    .wr_slot (wr_ptr_q),
    .wr_idx  (WIDX_W'(idx_q)),
    .wr_qw   (qw_pack(s_data, s_keep[4], s_last)),
    .rd_en   (pop),
    .rd_slot (rd_ptr_q),
    .rd_data (tlp_data)
  );

  assign tlp_valid    = valid_q;
  assign tlp_has_data = has_data_q;
  assign drop_cnt     = drop_q;

endmodule
